// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between a requester and alu_issue_ctrl.
// The requester uses the master modport and the issue controller uses the slave modport.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the single-cycle ALU: decodes requests, drives operands, holds MULT
// for MUL_LAT cycles and returns the tagged result. Optional perf counters: ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT    = 3'b100;
    localparam logic [3:0] CTRL_NONE  = 4'b0000;
    localparam logic [3:0] CTRL_MULT  = 4'b0101;
    localparam logic [3:0] MUL_CNT_LD = 4'(MUL_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_illegal;

    logic              w_in_ready;
    logic              w_out_valid;
    logic [3:0]        w_alu_ctrl;
    logic              w_accept;
    logic              w_in_illegal;
    logic              w_capture;
    logic              w_out_hs;

    function automatic logic [3:0] decode_op(input logic [2:0] op);
        case (op)
            3'b000:  decode_op = 4'b0001;
            3'b001:  decode_op = 4'b0010;
            3'b010:  decode_op = 4'b0011;
            3'b011:  decode_op = 4'b0100;
            3'b100:  decode_op = CTRL_MULT;
            default: decode_op = CTRL_NONE;
        endcase
    endfunction

    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_in_illegal = (bus.in_op > OP_MULT);
    assign w_out_hs     = w_out_valid & bus.out_ready;
    // MUL_LAT=1 loads cnt=0, so the first MUL cycle already captures, matching EXEC.
    assign w_capture    = (r_state == EXEC) || ((r_state == MUL) && (r_cnt == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_in_illegal) begin
                        w_state_next = DONE;
                    end else if (bus.in_op == OP_MULT) begin
                        w_state_next = MUL;
                    end else begin
                        w_state_next = EXEC;
                    end
                end
            end
            EXEC:    w_state_next = DONE;
            MUL:     w_state_next = (r_cnt == 4'd0) ? DONE : MUL;
            DONE:    w_state_next = bus.out_ready ? IDLE : DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_alu_ctrl  = CTRL_NONE;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            EXEC:    w_alu_ctrl  = decode_op(r_op);
            MUL:     w_alu_ctrl  = CTRL_MULT;
            DONE:    w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_out_tag <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.in_a;
                r_b   <= bus.in_b;
                r_op  <= bus.in_op;
                r_tag <= bus.in_tag;
                if (w_in_illegal) begin
                    r_result  <= '0;
                    r_illegal <= 1'b1;
                    r_out_tag <= bus.in_tag;
                end
                if (bus.in_op == OP_MULT) begin
                    r_cnt <= MUL_CNT_LD;
                end
            end
            if ((r_state == MUL) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_result  <= alu_result;
                r_illegal <= 1'b0;
                r_out_tag <= r_tag;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_out_hs) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
            // Cycles spent in the multiplier or waiting on a slow consumer.
            if ((r_state == MUL) || ((r_state == DONE) && !bus.out_ready)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_out_hs;
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_result  = r_result;
    assign bus.out_tag     = r_out_tag;
    assign bus.out_illegal = r_illegal;
    assign alu_a           = r_a;
    assign alu_b           = r_b;
    assign alu_ctrl        = w_alu_ctrl;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of single transactions plus hand-written
// sequences for reset, illegal op under backpressure and reset during MULT.
module tb_alu_issue_ctrl;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int MUL_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_stall;
`endif

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_result(alu_result)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    // Stand-in for the downstream single-cycle ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0001: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b0011: alu_result = alu_a & alu_b;
            4'b0100: alu_result = alu_a | alu_b;
            4'b0101: alu_result = alu_a * alu_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        ill;
        int          lat;
        logic [3:0]  ctrl;
    } vec_t;

    vec_t vecs[7];
    int   passed;
    int   total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int         edges;
        int         ctrl_cycles;
        logic [3:0] last_ctrl;
        check("in_ready_before", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = v.op;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_tag   = v.tag;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges       = 1;
        ctrl_cycles = 0;
        last_ctrl   = 4'd0;
        while (!bus.out_valid && edges < 40) begin
            if (alu_ctrl != 4'd0) begin
                ctrl_cycles++;
                last_ctrl = alu_ctrl;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("latency",     64'(edges),          64'(v.lat));
        check("ctrl_cycles", 64'(ctrl_cycles),    64'(v.lat - 1));
        check("ctrl_code",   {60'd0, last_ctrl},  {60'd0, v.ctrl});
        check("out_result",  {32'd0, bus.out_result}, {32'd0, v.res});
        check("out_tag",     {60'd0, bus.out_tag},    {60'd0, v.tag});
        check("out_illegal", {63'd0, bus.out_illegal}, {63'd0, v.ill});
        check("alu_a_held",  {32'd0, alu_a},      {32'd0, v.a});
        check("alu_b_held",  {32'd0, alu_b},      {32'd0, v.b});
        @(posedge clk); #1;
        check("valid_drop",  {63'd0, bus.out_valid}, 64'd0);
        $display("txn %0d op=%b a=%h b=%h tag=%h -> result=%h illegal=%b latency=%0d",
                 idx, v.op, v.a, v.b, v.tag, v.res, v.ill, edges);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{3'b000, 32'd5,        32'd7,        4'h3, 32'd12,       1'b0, 2,           4'b0001};
        vecs[1] = '{3'b001, 32'd0,        32'd1,        4'h5, 32'hFFFFFFFF, 1'b0, 2,           4'b0010};
        vecs[2] = '{3'b011, 32'h000000F0, 32'h0000000F, 4'h6, 32'h000000FF, 1'b0, 2,           4'b0100};
        vecs[3] = '{3'b010, 32'h000000F0, 32'h0000003C, 4'h7, 32'h00000030, 1'b0, 2,           4'b0011};
        vecs[4] = '{3'b100, 32'd6,        32'd7,        4'h8, 32'd42,       1'b0, MUL_LAT + 1, 4'b0101};
        vecs[5] = '{3'b100, 32'h00010000, 32'h00010000, 4'h9, 32'd0,        1'b0, MUL_LAT + 1, 4'b0101};
        vecs[6] = '{3'b101, 32'd9,        32'd9,        4'hA, 32'd0,        1'b1, 1,           4'b0000};

        // Reset state
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_alu_ctrl",  {60'd0, alu_ctrl},      64'd0);
        check("rst_alu_a",     {32'd0, alu_a},         64'd0);
        check("rst_alu_b",     {32'd0, alu_b},         64'd0);
        check("rst_out_result",{32'd0, bus.out_result}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], i);
        end

        // Illegal op held under backpressure; a competing request must be ignored.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'b110;
        bus.in_a      = 32'd3;
        bus.in_b      = 32'd4;
        bus.in_tag    = 4'hC;
        @(posedge clk); #1;
        bus.in_op  = 3'b000;
        bus.in_a   = 32'd1;
        bus.in_b   = 32'd2;
        bus.in_tag = 4'h1;
        check("ill_valid_1edge", {63'd0, bus.out_valid}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid",   {63'd0, bus.out_valid},   64'd1);
            check("bp_in_ready",    {63'd0, bus.in_ready},    64'd0);
            check("bp_out_result",  {32'd0, bus.out_result},  64'd0);
            check("bp_out_illegal", {63'd0, bus.out_illegal}, 64'd1);
            check("bp_out_tag",     {60'd0, bus.out_tag},     64'hC);
            check("bp_alu_ctrl",    {60'd0, alu_ctrl},        64'd0);
            check("bp_alu_a",       {32'd0, alu_a},           64'd3);
            $display("stall cycle %0d: out_valid=%b in_ready=%b", c, bus.out_valid, bus.in_ready);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_drop",  {63'd0, bus.out_valid}, 64'd0);
        check("hs_in_ready",    {63'd0, bus.in_ready},  64'd1);
        check("hs_no_accept",   {32'd0, alu_a},         64'd3);
        bus.in_valid = 1'b0;
        $display("illegal op released after backpressure");

        // Reset during the second MUL cycle discards the multiply.
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b100;
        bus.in_a     = 32'd6;
        bus.in_b     = 32'd7;
        bus.in_tag   = 4'h2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("mul_cycle1_ctrl", {60'd0, alu_ctrl}, 64'h5);
        @(posedge clk); #1;
        check("mul_cycle2_ctrl", {60'd0, alu_ctrl}, 64'h5);
        rst_n = 1'b0;
        #1;
        check("arst_alu_ctrl",  {60'd0, alu_ctrl},      64'd0);
        check("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_alu_a",     {32'd0, alu_a},         64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {63'd0, bus.out_valid}, 64'd0);
        end
        $display("reset during MULT: no response after release");
        run_op('{3'b000, 32'd1, 32'd1, 4'h4, 32'd2, 1'b0, 2, 4'b0001}, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
